// File: rtl/dds_pkg.sv
// Shared constants for the DDS phase accumulator: default widths, reset word,
// update-FSM encoding and named frequency words for a 50 MHz clk.
// Frequency words are round(f * 2^32 / 50e6) for a 32-bit accumulator.
package dds_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int FW_W_DEF   = 26;
  localparam int ADDR_W_DEF = 12;
  localparam int FW_RST_DEF = 86;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } upd_state_t;

  localparam int unsigned FW_1HZ    = 32'd86;
  localparam int unsigned FW_10HZ   = 32'd859;
  localparam int unsigned FW_100HZ  = 32'd8590;
  localparam int unsigned FW_1KHZ   = 32'd85899;
  localparam int unsigned FW_10KHZ  = 32'd858993;
  localparam int unsigned FW_100KHZ = 32'd8589935;
  localparam int unsigned FW_500KHZ = 32'd42949673;

endpackage

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator with glitch-free frequency-word update and ROM address stage.
// Latency: en -> acc 1 cycle, acc -> phase_addr 1 cycle (en -> addr_valid 2 cycles).
// Backpressure: fw_ready drops while a captured word waits to be applied; one word in flight.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en                  accumulate enable (acc holds when low)
//   fw_valid/fw_ready   frequency-word handshake, fw_data is the offered word
//   upd_sync            1: apply new word at accumulator wrap, 0: apply next cycle
//   phase_clr           synchronous accumulator clear, overrides accumulation
//   phase_off           offset added to the ROM address
//   phase_addr          registered ROM address, addr_valid marks it valid
//   wrap_pulse          one-cycle pulse after an update that carried out
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int FW_W   = FW_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FW_RST = FW_RST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fw_valid,
  input  logic [FW_W-1:0]   fw_data,
  output logic              fw_ready,
  input  logic              upd_sync,
  input  logic              phase_clr,
  input  logic [ADDR_W-1:0] phase_off,
  output logic [ADDR_W-1:0] phase_addr,
  output logic              addr_valid,
  output logic              wrap_pulse
);

  logic [ACC_W-1:0] acc;
  logic [FW_W-1:0]  f_cur;
  logic [FW_W-1:0]  f_pend;
  upd_state_t       state;
  upd_state_t       state_nxt;

  logic [ACC_W:0]   sum;
  logic             acc_step;
  logic             carry;
  logic             fw_take;
  logic             fw_apply;
  logic             en_d1;

  // One extra bit on the sum exposes the carry out of the accumulator.
  assign sum      = {1'b0, acc} + {{(ACC_W + 1 - FW_W){1'b0}}, f_cur};
  assign acc_step = en && !phase_clr;
  assign carry    = acc_step && sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // In sync mode the word waits for the wrap, except when no wrap can come
  // (stopped, zero step, or being cleared) so the sender is never stuck.
  always_comb begin
    state_nxt = state;
    fw_ready  = 1'b0;
    fw_take   = 1'b0;
    fw_apply  = 1'b0;
    case (state)
      ST_RUN: begin
        fw_ready = 1'b1;
        if (fw_valid) begin
          fw_take   = 1'b1;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!upd_sync || !en || phase_clr || (f_cur == '0) || carry) begin
          fw_apply  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      f_cur      <= FW_W'(FW_RST);
      f_pend     <= '0;
      wrap_pulse <= 1'b0;
      phase_addr <= '0;
      en_d1      <= 1'b0;
      addr_valid <= 1'b0;
    end else begin
      if (phase_clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= sum[ACC_W-1:0];
      end
      wrap_pulse <= carry;
      phase_addr <= acc[ACC_W-1 -: ADDR_W] + phase_off;
      en_d1      <= en;
      addr_valid <= en_d1;
      if (fw_take) begin
        f_pend <= fw_data;
      end
      // On a wrap-synchronous apply the carrying update above still used the
      // old f_cur; the new word drives the next increment.
      if (fw_apply) begin
        f_cur <= f_pend;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_acc.sv
module tb_dds_phase_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fw_valid = 1'b0;
  logic [25:0] fw_data = '0;
  logic        fw_ready;
  logic        upd_sync = 1'b0;
  logic        phase_clr = 1'b0;
  logic [11:0] phase_off = '0;
  logic [11:0] phase_addr;
  logic        addr_valid;
  logic        wrap_pulse;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [25:0] F24 = 26'h100_0000;
  localparam logic [25:0] F25 = 26'h200_0000;

  dds_phase_acc dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fw_valid   (fw_valid),
    .fw_data    (fw_data),
    .fw_ready   (fw_ready),
    .upd_sync   (upd_sync),
    .phase_clr  (phase_clr),
    .phase_off  (phase_off),
    .phase_addr (phase_addr),
    .addr_valid (addr_valid),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; fw_valid = 1'b0; phase_clr = 1'b0;
    phase_off = '0; upd_sync = 1'b0; fw_data = '0;
    tick();
    rst = 1'b0;
  endtask

  // Immediate-mode load with the accumulator stopped: capture, then apply.
  task automatic load_word(input logic [25:0] w);
    upd_sync = 1'b0; fw_data = w; fw_valid = 1'b1;
    tick();
    fw_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (fw_ready !== 1'b1) begin n_err++; $display("FAIL reset_fw_ready: got %0h want 1", fw_ready); end
    n_cmp++; if (phase_addr !== 12'h000) begin n_err++; $display("FAIL reset_phase_addr: got %0h want 0", phase_addr); end
    n_cmp++; if (addr_valid !== 1'b0) begin n_err++; $display("FAIL reset_addr_valid: got %0h want 0", addr_valid); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %0h want 0", wrap_pulse); end
    n_cmp++; if (dut.f_cur !== 26'd86) begin n_err++; $display("FAIL reset_f_cur: got %0d want 86", dut.f_cur); end
    n_cmp++; if (dut.acc !== 32'h0) begin n_err++; $display("FAIL reset_acc: got %0h want 0", dut.acc); end
  endtask

  task automatic test_basic;
    logic [11:0] exp_pa;
    logic        exp_wrap;
    do_reset();
    load_word(F24);
    en = 1'b1;
    for (int k = 1; k <= 520; k++) begin
      tick();
      exp_pa   = 12'((k - 1) * 16);
      exp_wrap = (k % 256) == 0;
      n_cmp++; if (addr_valid !== (k >= 2)) begin n_err++; $display("FAIL basic_addr_valid k=%0d: got %0h want %0h", k, addr_valid, k >= 2); end
      n_cmp++; if (phase_addr !== exp_pa) begin n_err++; $display("FAIL basic_phase_addr k=%0d: got %0h want %0h", k, phase_addr, exp_pa); end
      n_cmp++; if (wrap_pulse !== exp_wrap) begin n_err++; $display("FAIL basic_wrap k=%0d: got %0h want %0h", k, wrap_pulse, exp_wrap); end
    end
    en = 1'b0;
  endtask

  task automatic test_sync_update;
    logic [11:0] exp_pa;
    logic        exp_wrap;
    logic        exp_rdy;
    do_reset();
    load_word(F24);
    upd_sync = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 520; k++) begin
      tick();
      exp_rdy  = !(k >= 129 && k <= 255);
      exp_wrap = (k == 256) || (k == 384) || (k == 512);
      exp_pa   = (k <= 256) ? 12'((k - 1) * 16) : 12'((k - 257) * 32);
      n_cmp++; if (fw_ready !== exp_rdy) begin n_err++; $display("FAIL sync_fw_ready k=%0d: got %0h want %0h", k, fw_ready, exp_rdy); end
      n_cmp++; if (wrap_pulse !== exp_wrap) begin n_err++; $display("FAIL sync_wrap k=%0d: got %0h want %0h", k, wrap_pulse, exp_wrap); end
      n_cmp++; if (phase_addr !== exp_pa) begin n_err++; $display("FAIL sync_phase_addr k=%0d: got %0h want %0h", k, phase_addr, exp_pa); end
      if (k == 200) begin
        n_cmp++; if (dut.f_pend !== F25) begin n_err++; $display("FAIL sync_held_word: got %0h want %0h", dut.f_pend, F25); end
        n_cmp++; if (dut.f_cur !== F24) begin n_err++; $display("FAIL sync_f_cur_before: got %0h want %0h", dut.f_cur, F24); end
      end
      if (k == 256) begin
        n_cmp++; if (dut.f_cur !== F25) begin n_err++; $display("FAIL sync_f_cur_after: got %0h want %0h", dut.f_cur, F25); end
      end
      // k=128 leaves acc at 0x8000_0000; the k=150 offer must be ignored.
      fw_valid = (k == 128) || (k == 150);
      fw_data  = (k == 150) ? 26'd5 : F25;
    end
    fw_valid = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_immediate;
    int          u_prev;
    logic [11:0] exp_pa;
    do_reset();
    load_word(F24);
    upd_sync = 1'b0;
    en = 1'b1;
    fw_data = F25;
    for (int k = 1; k <= 20; k++) begin
      tick();
      u_prev = (k - 1 <= 12) ? (k - 1) : (12 + 2 * (k - 13));
      exp_pa = 12'(u_prev * 16);
      n_cmp++; if (fw_ready !== (k != 11)) begin n_err++; $display("FAIL imm_fw_ready k=%0d: got %0h want %0h", k, fw_ready, k != 11); end
      n_cmp++; if (phase_addr !== exp_pa) begin n_err++; $display("FAIL imm_phase_addr k=%0d: got %0h want %0h", k, phase_addr, exp_pa); end
      fw_valid = (k == 10);
    end
    en = 1'b0;
  endtask

  task automatic test_fzero;
    do_reset();
    load_word(26'd0);
    en = 1'b1;
    upd_sync = 1'b1;
    tick();
    n_cmp++; if (dut.acc !== 32'h0) begin n_err++; $display("FAIL fzero_frozen: got %0h want 0", dut.acc); end
    fw_data = F24; fw_valid = 1'b1;
    tick();
    fw_valid = 1'b0;
    n_cmp++; if (fw_ready !== 1'b0) begin n_err++; $display("FAIL fzero_pend_ready: got %0h want 0", fw_ready); end
    tick();
    n_cmp++; if (fw_ready !== 1'b1) begin n_err++; $display("FAIL fzero_ready_back: got %0h want 1", fw_ready); end
    n_cmp++; if (dut.f_cur !== F24) begin n_err++; $display("FAIL fzero_applied: got %0h want %0h", dut.f_cur, F24); end
    n_cmp++; if (dut.acc !== 32'h0) begin n_err++; $display("FAIL fzero_acc_still0: got %0h want 0", dut.acc); end
    tick();
    n_cmp++; if (dut.acc !== 32'h0100_0000) begin n_err++; $display("FAIL fzero_acc_step: got %0h want 1000000", dut.acc); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL fzero_wrap: got %0h want 0", wrap_pulse); end
    en = 1'b0;
  endtask

  task automatic test_phase_clr;
    do_reset();
    load_word(F24);
    en = 1'b1;
    for (int k = 1; k <= 255; k++) tick();
    // Clear lands on the edge that would otherwise carry out.
    phase_off = 12'h400;
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    n_cmp++; if (dut.acc !== 32'h0) begin n_err++; $display("FAIL clr_acc: got %0h want 0", dut.acc); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL clr_wrap_0: got %0h want 0", wrap_pulse); end
    n_cmp++; if (phase_addr !== 12'd1008) begin n_err++; $display("FAIL clr_addr_0: got %0h want 3f0", phase_addr); end
    tick();
    n_cmp++; if (phase_addr !== 12'h400) begin n_err++; $display("FAIL clr_addr_1: got %0h want 400", phase_addr); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL clr_wrap_1: got %0h want 0", wrap_pulse); end
    tick();
    n_cmp++; if (phase_addr !== 12'h410) begin n_err++; $display("FAIL clr_addr_2: got %0h want 410", phase_addr); end
    en = 1'b0;
    phase_off = '0;
  endtask

  task automatic test_hold;
    do_reset();
    en = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (dut.acc !== 32'd258) begin n_err++; $display("FAIL hold_acc_run: got %0d want 258", dut.acc); end
    en = 1'b0;
    tick();
    n_cmp++; if (dut.acc !== 32'd258) begin n_err++; $display("FAIL hold_acc_0: got %0d want 258", dut.acc); end
    n_cmp++; if (addr_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid_0: got %0h want 1", addr_valid); end
    tick();
    n_cmp++; if (dut.acc !== 32'd258) begin n_err++; $display("FAIL hold_acc_1: got %0d want 258", dut.acc); end
    n_cmp++; if (addr_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid_1: got %0h want 0", addr_valid); end
  endtask

  task automatic test_reset_pend;
    do_reset();
    load_word(F24);
    en = 1'b1;
    upd_sync = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    fw_data = F25; fw_valid = 1'b1;
    tick();
    fw_valid = 1'b0;
    n_cmp++; if (fw_ready !== 1'b0) begin n_err++; $display("FAIL rpend_in_pend: got %0h want 0", fw_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (fw_ready !== 1'b1) begin n_err++; $display("FAIL rpend_fw_ready: got %0h want 1", fw_ready); end
    n_cmp++; if (dut.f_cur !== 26'd86) begin n_err++; $display("FAIL rpend_f_cur: got %0d want 86", dut.f_cur); end
    n_cmp++; if (dut.acc !== 32'h0) begin n_err++; $display("FAIL rpend_acc: got %0h want 0", dut.acc); end
    n_cmp++; if (dut.f_pend !== 26'd0) begin n_err++; $display("FAIL rpend_f_pend: got %0h want 0", dut.f_pend); end
    n_cmp++; if (addr_valid !== 1'b0) begin n_err++; $display("FAIL rpend_addr_valid: got %0h want 0", addr_valid); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sync_update();
    test_immediate();
    test_fzero();
    test_phase_clr();
    test_hold();
    test_reset_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dds_phase_acc.md
DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

Interface
REQ-001 The block SHALL have parameter ACC_W, default 32, the phase accumulator width.
REQ-002 The block SHALL have parameter FW_W, default 26, the frequency-word width, zero-extended to ACC_W.
REQ-003 The block SHALL have parameter ADDR_W, default 12, the waveform-ROM address width.
REQ-004 The block SHALL have parameter FW_RST, default 86, the frequency word loaded at reset (1 Hz at 50 MHz).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: accumulate enable.
REQ-008 The block SHALL have port fw_valid, input, 1 bit: new frequency word offered.
REQ-009 The block SHALL have port fw_data, input, FW_W bits: the offered frequency word.
REQ-010 The block SHALL have port fw_ready, output, 1 bit: the block can accept a word.
REQ-011 The block SHALL have port upd_sync, input, 1 bit: 1 applies a new word at the accumulator wrap, 0 applies it immediately.
REQ-012 The block SHALL have port phase_clr, input, 1 bit: synchronous accumulator clear.
REQ-013 The block SHALL have port phase_off, input, ADDR_W bits: the phase offset added to the address.
REQ-014 The block SHALL have port phase_addr, output, ADDR_W bits: the ROM address.
REQ-015 The block SHALL have port addr_valid, output, 1 bit: phase_addr is valid this cycle.
REQ-016 The block SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse on accumulator carry-out.

Function
REQ-017 The block SHALL hold registers acc (ACC_W bits), f_cur (FW_W bits), f_pend (FW_W bits) and a two-state FSM {ST_RUN, ST_PEND}.
REQ-018 When en=1 and phase_clr=0, acc SHALL load (acc + zero-extended f_cur) mod 2^ACC_W each cycle; when en=0, acc SHALL hold.
REQ-019 wrap_pulse SHALL be 1 in the cycle after any update whose sum carries out of bit ACC_W-1, and 0 otherwise.
REQ-020 phase_addr SHALL register (acc[ACC_W-1 -: ADDR_W] + phase_off) mod 2^ADDR_W.
REQ-021 addr_valid SHALL register en delayed by 2 cycles, so the en-to-addr_valid latency is exactly 2 cycles.
REQ-022 fw_ready SHALL be 1 in ST_RUN and 0 in ST_PEND.
REQ-023 A handshake (fw_valid=1 and fw_ready=1) SHALL capture fw_data into f_pend and move the FSM to ST_PEND.
REQ-024 In ST_PEND with upd_sync=0, the block SHALL set f_cur <= f_pend in the next cycle and return to ST_RUN.
REQ-025 In ST_PEND with upd_sync=1, the block SHALL apply f_pend in the cycle whose acc update carries out; that update still uses the old f_cur, and the new word takes effect from the following increment.
REQ-026 In ST_PEND with upd_sync=1, the block SHALL instead apply f_pend immediately, in the next cycle, if any of the following holds, since no wrap can occur:
- en=0
- f_cur=0
- phase_clr=1
REQ-027 phase_clr=1 SHALL set acc <= 0 and SHALL override accumulation; wrap_pulse SHALL be 0 for that update.
REQ-028 There SHALL be no case where a word is accepted and applied in the same cycle, because fw_ready=0 throughout ST_PEND.
REQ-029 fw_data=0 SHALL be legal and SHALL freeze the phase after it is applied.
REQ-030 A word offered while fw_ready=0 SHALL NOT be captured; the sender holds it until acceptance.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL reset as follows:
- acc <= 0
- f_cur <= FW_RST
- f_pend <= 0
- FSM <= ST_RUN
- phase_addr, addr_valid and wrap_pulse <= 0
- fw_ready = 1 in the following cycle
REQ-032 rst SHALL take priority over all other inputs, and a pending word SHALL be discarded by reset mid-operation.

Structure
REQ-033 A shared package dds_pkg SHALL hold the default widths, FW_RST, the FSM state encoding, and the named frequency-word constants (1 Hz .. 500 kHz).
REQ-034 dds_phase_acc SHALL be a single module with no sub-module, because the accumulator, update FSM and address stage are too small to justify one.

Verification
REQ-035 Reset, then en=1 with f_cur loaded to 2^24: addr_valid SHALL rise 2 cycles after en, phase_addr SHALL step by 16 each cycle, and wrap_pulse SHALL fire every 256 cycles.
REQ-036 With f_cur=2^24 and upd_sync=1, offer fw_data=2^25 when acc=0x8000_0000:
- fw_ready SHALL be 0 until the wrap 128 cycles later.
- phase_addr SHALL then step by 32 per cycle.
- wrap_pulse SHALL then fire every 128 cycles.
REQ-037 With upd_sync=0, offer fw_data=2^25: fw_ready SHALL return to 1 after 2 cycles, and the phase_addr step SHALL change to 32 immediately after.
REQ-038 With f_cur=0 and upd_sync=1, offer fw_data=2^24: the word SHALL apply in the next cycle even though no wrap occurs.
REQ-039 Assert phase_clr with phase_off=0x400: phase_addr SHALL equal 0x400 two cycles later, and wrap_pulse SHALL stay 0.
REQ-040 Assert rst while in ST_PEND: the cycle after reset, fw_ready=1, f_cur=86, and acc=0.
